// File: rtl/mac_operand_seq.sv
// Operand sequencer feeding the 4-bit signed MAC.
// Holds two operand vectors loaded by a host port and, on start, streams
// A[i]/B[i] pairs one per cycle, then idles DRAIN_CYC cycles so the MAC
// accumulator settles before done pulses.
//
// state | meaning
// IDLE  | waiting for start; host writes accepted
// RUN   | one operand pair presented per cycle
// DRAIN | valids low while the MAC finishes accumulating
// DONE  | one-cycle done pulse, then back to IDLE
module mac_operand_seq #(
    parameter int DW        = 4,
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int DRAIN_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [DW-1:0] wr_data,
    input  logic                 start,
    input  logic [AW:0]          len,
    output logic signed [DW-1:0] out_a,
    output logic signed [DW-1:0] out_b,
    output logic                 out_valid_a,
    output logic                 out_valid_b,
    output logic                 last,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err
);

    localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic signed [DW-1:0]  mem_a [DEPTH];
    logic signed [DW-1:0]  mem_b [DEPTH];
    logic [AW-1:0]         idx;
    logic [AW:0]           len_q;
    logic [AW:0]           len_c;
    logic [CW-1:0]         cnt;

    // Requests longer than the vectors are clamped rather than wrapping.
    assign len_c = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;

    // Host write port: only accepted while idle; rejected writes flag wr_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && (state != IDLE);
            if (wr_en && (state == IDLE) && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
                if (wr_sel)
                    mem_b[wr_addr] <= wr_data;
                else
                    mem_a[wr_addr] <= wr_data;
            end
        end
    end

    // Sequencing FSM; every output is produced directly from a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            len_q       <= '0;
            cnt         <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_valid_a <= 1'b0;
            out_valid_b <= 1'b0;
            last        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q <= len_c;
                        busy  <= 1'b1;
                        if (len_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // First pair is registered on the sampling edge so
                            // it is visible in the very next cycle.
                            state       <= RUN;
                            out_a       <= mem_a[0];
                            out_b       <= mem_b[0];
                            out_valid_a <= 1'b1;
                            out_valid_b <= 1'b1;
                            last        <= (len_c == (AW+1)'(1));
                            idx         <= AW'(1);
                        end
                    end
                end

                RUN: begin
                    if (last) begin
                        // The final pair has just been presented.
                        out_a       <= '0;
                        out_b       <= '0;
                        out_valid_a <= 1'b0;
                        out_valid_b <= 1'b0;
                        last        <= 1'b0;
                        cnt         <= '0;
                        if (DRAIN_CYC == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        out_a <= mem_a[idx];
                        out_b <= mem_b[idx];
                        last  <= ({1'b0, idx} == len_q - (AW+1)'(1));
                        idx   <= idx + AW'(1);
                    end
                end

                DRAIN: begin
                    if (cnt == CW'(DRAIN_CYC - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DONE: begin
                    // start is deliberately ignored here; a held start
                    // launches again from the following IDLE cycle.
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_seq.sv
// Scoreboard bench for mac_operand_seq: the stimulus side models the
// operand memories and pushes expected pairs and done events; a monitor
// pops and compares whenever the DUT presents a pair or a done pulse.
module tb_mac_operand_seq;

    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DRAIN = 2;

    logic                 clk;
    logic                 reset;
    logic                 wr_en;
    logic                 wr_sel;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;
    logic                 start;
    logic [AW:0]          len;
    logic signed [DW-1:0] out_a;
    logic signed [DW-1:0] out_b;
    logic                 out_valid_a;
    logic                 out_valid_b;
    logic                 last;
    logic                 busy;
    logic                 done;
    logic                 wr_err;

    mac_operand_seq #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .len(len),
        .out_a(out_a), .out_b(out_b), .out_valid_a(out_valid_a),
        .out_valid_b(out_valid_b), .last(last), .busy(busy), .done(done),
        .wr_err(wr_err)
    );

    typedef struct {
        int a;
        int b;
        int lst;
        int cyc;
    } pair_t;

    typedef struct {
        int cyc;
        int dot;
    } done_t;

    pair_t pq[$];
    done_t dq[$];
    int    ref_a [DEPTH];
    int    ref_b [DEPTH];
    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    mac     = 0;
    int    err_exp = -1;
    bit    prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream for one sequence whose start is sampled at edge e.
    function automatic void push_seq(input int e, input int lc);
        pair_t p;
        done_t d;
        int    dot = 0;
        for (int k = 0; k < lc; k++) begin
            p.a   = ref_a[k];
            p.b   = ref_b[k];
            p.lst = (k == lc - 1) ? 1 : 0;
            p.cyc = e + k;
            pq.push_back(p);
            dot += ref_a[k] * ref_b[k];
        end
        d.cyc = (lc == 0) ? e : e + lc + DRAIN;
        d.dot = dot;
        dq.push_back(d);
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard.
    pair_t mp;
    done_t md;
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid_a || out_valid_b) begin
                check("valid_split", int'(out_valid_b), int'(out_valid_a));
                check("busy_in_run", int'(busy), 1);
                if (pq.size() == 0) begin
                    check("unexpected_pair", 1, 0);
                end else begin
                    mp = pq.pop_front();
                    check("pair_cycle", cyc, mp.cyc);
                    check("out_a", int'(out_a), mp.a);
                    check("out_b", int'(out_b), mp.b);
                    check("last", int'(last), mp.lst);
                end
                mac += int'(out_a) * int'(out_b);
            end else if (last) begin
                check("last_without_valid", int'(last), 0);
            end
            if (done) begin
                check("busy_in_done", int'(busy), 1);
                if (dq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    md = dq.pop_front();
                    check("done_cycle", cyc, md.cyc);
                    check("mac_result", mac, md.dot);
                end
                mac = 0;
            end
            if (prev_done)
                check("busy_after_done", int'(busy), 0);
            prev_done = done;
            if (wr_err || cyc == err_exp)
                check("wr_err", int'(wr_err), (cyc == err_exp) ? 1 : 0);
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic write_op(input bit sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = DW'(data);
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) ref_b[addr] = int'(wr_data);
        else     ref_a[addr] = int'(wr_data);
    endtask

    // Issue start at a negedge; returns at the negedge of the first pair cycle.
    task automatic run_seq(input int l);
        int lc;
        lc    = (l > DEPTH) ? DEPTH : l;
        start = 1'b1;
        len   = (AW+1)'(l);
        push_seq(cyc + 1, lc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pq.size() != 0 || dq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (pq.size() != 0 || dq.size() != 0) begin
            check("timeout_outstanding", pq.size() + dq.size(), 0);
            pq.delete();
            dq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int lc, e, period;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        len     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_a[i] = 0;
            ref_b[i] = 0;
        end
        #12;
        check("reset_outputs", int'({out_a, out_b, out_valid_a, out_valid_b, last, busy, done, wr_err}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic dot product: 1*5 + 2*-6 + 3*7 + -4*8 = -18
        write_op(0, 0, 1);  write_op(0, 1, 2);  write_op(0, 2, 3);  write_op(0, 3, -4);
        write_op(1, 0, 5);  write_op(1, 1, -6); write_op(1, 2, 7);  write_op(1, 3, 8);
        run_seq(4);
        wait_idle();

        // Full depth: 8 * (7 * -8) = -448
        for (int i = 0; i < DEPTH; i++) begin
            write_op(0, i, 7);
            write_op(1, i, -8);
        end
        run_seq(8);
        wait_idle();

        // len = 0 and a clamped len = 12
        run_seq(0);
        wait_idle();
        run_seq(12);
        wait_idle();

        // Write during the second RUN cycle must be rejected.
        write_op(0, 1, 2);
        write_op(1, 1, 3);
        run_seq(5);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd1; wr_data = 4'sd5;
        err_exp = cyc + 1;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle();
        run_seq(5);
        wait_idle();

        // start pulses during RUN are ignored.
        run_seq(6);
        @(negedge clk);
        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held high: back-to-back sequences, one IDLE cycle between.
        lc     = 4;
        period = lc + DRAIN + 2;
        e      = cyc + 1;
        start  = 1'b1;
        len    = 4'd4;
        for (int s = 0; s < 3; s++)
            push_seq(e + s * period, lc);
        for (int n = 0; n < 100 && cyc < e + 2 * period; n++)
            @(negedge clk);
        start = 1'b0;
        wait_idle();

        // len = 0 held: done every other cycle.
        e     = cyc + 1;
        start = 1'b1;
        len   = 4'd0;
        push_seq(e, 0);
        push_seq(e + 2, 0);
        for (int n = 0; n < 100 && cyc < e + 2; n++)
            @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset during the third pair aborts immediately and clears memories.
        run_seq(4);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_abort_outputs", int'({out_a, out_b, out_valid_a, out_valid_b, last, busy, done, wr_err}), 0);
        pq.delete();
        dq.delete();
        mac = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_a[i] = 0;
            ref_b[i] = 0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        run_seq(4);
        wait_idle();

        // Randomized writes and sequences against the model.
        for (int it = 0; it < 25; it++) begin
            for (int w = 0; w < int'($urandom_range(2, 6)); w++)
                write_op(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                         int'($urandom_range(0, 15)) - 8);
            run_seq(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) begin
                start = 1'b1;
                len   = 4'($urandom_range(0, 15));
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle();
        end

        check("queues_drained", pq.size() + dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_operand_seq.md
Name: mac_operand_seq

Overview:
- Operand sequencer directly upstream of the 4-bit signed MAC unit.
- Holds two small operand vectors (A and B) written by a host port.
- On start, streams A[i]/B[i] pairs one per cycle on the MAC's in_a/in_b/in_valid_a/in_valid_b inputs, then waits a fixed drain interval so the MAC's accumulated dot product is settled before it pulses done.

Parameters:
- DW, 4, operand width in bits (signed); matches the MAC operand width.
- DEPTH, 8, entries per vector.
- AW, 3, address width; must equal clog2(DEPTH).
- DRAIN_CYC, 2, idle cycles after the last pair before done.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- wr_en  in  1  host write strobe.
- wr_sel  in  1  0 = write vector A, 1 = write vector B.
- wr_addr  in  AW  write index.
- wr_data  in  DW  signed operand to store.
- start  in  1  begin a sequence (level sampled each cycle).
- len  in  AW+1  number of pairs to issue, 0..DEPTH.
- out_a  out  DW  signed operand to MAC in_a.
- out_b  out  DW  signed operand to MAC in_b.
- out_valid_a  out  1  to MAC in_valid_a.
- out_valid_b  out  1  to MAC in_valid_b.
- last  out  1  high with the final pair.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- wr_err  out  1  one-cycle pulse: write rejected while busy.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; all outputs 0; both vector memories cleared to 0; index and drain counters 0. Reset asserted mid-sequence aborts immediately: valids drop without waiting for the next clock, and no done is produced.
- All outputs are registered.
- Writes:
  - In IDLE, wr_en stores wr_data into A[wr_addr] or B[wr_addr], selected by wr_sel.
  - In any other state the write is dropped and wr_err pulses high the next cycle.
  - wr_addr >= DEPTH is dropped with no error.
- Length: captured at start. len > DEPTH is clamped to DEPTH.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - start=1 and len>0: go to RUN with idx=0.
    - start=1 and len=0: go to DONE.
    - start is ignored in every other state.
  - RUN:
    - Each cycle, registers out_a=A[idx], out_b=B[idx], and both valids = 1.
    - last=1 when idx = len-1.
    - After that final pair, go to DRAIN with cnt=0.
  - DRAIN:
    - Valids = 0, last = 0, out_a/out_b = 0.
    - Lasts DRAIN_CYC cycles, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Timing, with start sampled at edge t0:
  - Pair k is visible on outputs during cycle t0+1+k.
  - Valids are low from t0+1+len.
  - done is high during cycle t0+1+len+DRAIN_CYC.
  - busy is high from t0+1 through the done cycle inclusive, low otherwise.
  - len=0: done is high at t0+1 and busy is high only that cycle; no valids are issued.
- Back-to-back: start held high during the done cycle is ignored. The next sequence may start on the first IDLE cycle, with the same t0 timing.
- Valids are never split: out_valid_a always equals out_valid_b. This keeps the MAC in its MAC state for consecutive pairs.
- Memory contents persist across sequences until overwritten or reset.

Test Plan:
- Basic dot product:
  - Stimulus: write A = {1, 2, 3, -4}, B = {5, -6, 7, 8}; start with len = 4.
  - Required: four consecutive cycles of valid pairs, last on the 4th pair; done exactly 1 + 4 + 2 = 7 cycles after start; downstream MAC output = -18.
- Full depth:
  - Stimulus: A[i] = 7, B[i] = -8 for all 8 entries; len = 8.
  - Required: 8 pairs issued; MAC output = -448; no wrap past idx 7.
- len = 0 and len = 12:
  - len = 0: done one cycle after start, zero valid cycles.
  - len = 12: clamped to 8 pairs.
- Write during busy:
  - Stimulus: wr_en with wr_sel = 0, wr_addr = 1, wr_data = 5 in the 2nd RUN cycle.
  - Required: wr_err pulses; A[1] unchanged, as confirmed by a second sequence reproducing the same result.
- Reset mid-RUN:
  - Stimulus: drive reset = 0 between edges during the 3rd pair.
  - Required: all outputs 0 immediately; no done; after release, memories read 0 (a sequence of len 4 yields MAC output 0).
- Start while busy / back-to-back:
  - start pulses during RUN are ignored.
  - start held high continuously: the second sequence begins on the first cycle after done, giving identical pair timing.
